// File: rtl/texel_serializer_pkg.sv
// Shared texel types, frame marker defaults and word-index encoding for the texel
// serializer/assembler pair. Latency: n/a (types only). Backpressure: n/a.
package texel_serializer_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } Vertex3D;

  typedef struct packed {
    Vertex3D p;
    Vertex3D q;
    Vertex3D r;
  } Triangle3D;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } Color;

  // 144-bit triangle plus 24-bit colour: the 168-bit holding register
  typedef struct packed {
    Triangle3D vert;
    Color      col;
  } texel_t;

  localparam logic [31:0] FRAME_START_WORD = 32'd0;
  localparam logic [31:0] FRAME_END_WORD   = 32'd1;

  // Position of each 32-bit word within an outgoing frame
  typedef enum logic [2:0] {
    IDX_START = 3'd0,
    IDX_PYX   = 3'd1,
    IDX_QXPZ  = 3'd2,
    IDX_QZY   = 3'd3,
    IDX_RYX   = 3'd4,
    IDX_GRRZ  = 3'd5,
    IDX_B     = 3'd6,
    IDX_END   = 3'd7
  } word_idx_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/texel_serializer.sv
// Captures one texel and emits it as an 8-word frame (start, 6 payload, end); first word one cycle
// after capture, 9-cycle period. Backpressure: ahb_buffer_full freezes the current word and index.
module texel_serializer
  import texel_serializer_pkg::*;
#(
  parameter logic [31:0] FRAME_START = FRAME_START_WORD,
  parameter logic [31:0] FRAME_END   = FRAME_END_WORD
) (
  input  logic        clk,
  input  logic        n_rst,
  input  Triangle3D   texel_vertices_in,
  input  Color        texel_color_in,
  input  logic        texel_valid,
  output logic        texel_accept,
  output logic [31:0] ahb_write_buffer,
  output logic        ahb_write_valid,
  input  logic        ahb_buffer_full
);

  state_e      r_state;
  word_idx_e   r_idx;
  texel_t      r_hold;
  logic [31:0] r_word;
  logic        r_vld;

  word_idx_e   w_next_idx;
  logic [31:0] w_next_word;
  logic        w_xfer;

  // Gated by n_rst so the producer never sees an accept while reset is held
  assign texel_accept     = (r_state == ST_IDLE) && n_rst;
  assign ahb_write_buffer = r_word;
  assign ahb_write_valid  = r_vld;

  assign w_xfer     = r_vld && !ahb_buffer_full;
  assign w_next_idx = word_idx_e'(r_idx + 3'd1);

  // Word that becomes visible after the current one transfers
  always_comb begin
    w_next_word = 32'h0;
    case (w_next_idx)
      IDX_START: w_next_word = FRAME_START;
      IDX_PYX:   w_next_word = {r_hold.vert.p.y, r_hold.vert.p.x};
      IDX_QXPZ:  w_next_word = {r_hold.vert.q.x, r_hold.vert.p.z};
      IDX_QZY:   w_next_word = {r_hold.vert.q.z, r_hold.vert.q.y};
      IDX_RYX:   w_next_word = {r_hold.vert.r.y, r_hold.vert.r.x};
      IDX_GRRZ:  w_next_word = {r_hold.col.g, r_hold.col.r, r_hold.vert.r.z};
      IDX_B:     w_next_word = {24'h0, r_hold.col.b};
      IDX_END:   w_next_word = FRAME_END;
      default:   w_next_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
      r_idx   <= IDX_START;
      r_hold  <= '0;
      r_word  <= 32'h0;
      r_vld   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (texel_valid) begin
            r_hold  <= '{vert: texel_vertices_in, col: texel_color_in};
            r_state <= ST_SEND;
            r_idx   <= IDX_START;
            r_word  <= FRAME_START;
            r_vld   <= 1'b1;
          end
        end
        ST_SEND: begin
          if (w_xfer) begin
            if (r_idx == IDX_END) begin
              r_state <= ST_IDLE;
              r_idx   <= IDX_START;
              r_word  <= 32'h0;
              r_vld   <= 1'b0;
            end else begin
              r_idx  <= w_next_idx;
              r_word <= w_next_word;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= IDX_START;
          r_word  <= 32'h0;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_texel_serializer.sv
// Bench for texel_serializer: directed tables, corner sequences, loopback unpacking and a
// randomized run against a queue-based frame model.
module tb_texel_serializer;
  import texel_serializer_pkg::*;

  // Texel as flat lists: v = p.x,p.y,p.z,q.x,q.y,q.z,r.x,r.y,r.z ; c = r,g,b
  typedef struct packed {
    logic [8:0][15:0] v;
    logic [2:0][7:0]  c;
  } tx_t;

  typedef struct packed {
    logic        full;
    logic [31:0] word;
  } vec_t;

  localparam logic [31:0] START_W = 32'd0;
  localparam logic [31:0] END_W   = 32'd1;

  logic        clk;
  logic        n_rst;
  Triangle3D   texel_vertices_in;
  Color        texel_color_in;
  logic        texel_valid;
  logic        texel_accept;
  logic [31:0] ahb_write_buffer;
  logic        ahb_write_valid;
  logic        ahb_buffer_full;

  int total = 0;
  int bad   = 0;

  texel_serializer #(
    .FRAME_START(START_W),
    .FRAME_END  (END_W)
  ) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .texel_vertices_in(texel_vertices_in),
    .texel_color_in   (texel_color_in),
    .texel_valid      (texel_valid),
    .texel_accept     (texel_accept),
    .ahb_write_buffer (ahb_write_buffer),
    .ahb_write_valid  (ahb_write_valid),
    .ahb_buffer_full  (ahb_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Word k of the frame carrying texel t, straight from the packing rules
  function automatic logic [31:0] frame_word(input tx_t t, input int k);
    logic [31:0] w;
    if (k == 0)                w = START_W;
    else if (k >= 1 && k <= 4) w = {t.v[2*k-1], t.v[2*k-2]};
    else if (k == 5)           w = {t.c[1], t.c[0], t.v[8]};
    else if (k == 6)           w = {24'h0, t.c[2]};
    else                       w = END_W;
    return w;
  endfunction

  task automatic drive_tx(input tx_t t);
    Triangle3D tr;
    Color      cl;
    tr.p = '{x: t.v[0], y: t.v[1], z: t.v[2]};
    tr.q = '{x: t.v[3], y: t.v[4], z: t.v[5]};
    tr.r = '{x: t.v[6], y: t.v[7], z: t.v[8]};
    cl   = '{r: t.c[0], g: t.c[1], b: t.c[2]};
    texel_vertices_in = tr;
    texel_color_in    = cl;
  endtask

  function automatic tx_t rand_tx();
    tx_t t;
    for (int i = 0; i < 9; i++) t.v[i] = 16'($urandom);
    for (int i = 0; i < 3; i++) t.c[i] = 8'($urandom);
    return t;
  endfunction

  // Let the current frame finish with no backpressure, bounded
  task automatic drain();
    int n = 0;
    ahb_buffer_full = 1'b0;
    texel_valid     = 1'b0;
    while (ahb_write_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", {31'd0, ahb_write_valid}, 32'd0);
  endtask

  task automatic capture(input tx_t t);
    drive_tx(t);
    texel_valid = 1'b1;
    @(negedge clk);
    texel_valid = 1'b0;
  endtask

  tx_t         ta, tb, lb;
  logic [31:0] w8 [8];
  vec_t        bp_tab [11];
  logic [31:0] q [$];

  initial begin
    ta.v = {16'h3210, 16'hFFEE, 16'hDDCC, 16'hBBAA, 16'h9988, 16'h7766,
            16'h5544, 16'h3322, 16'h1100};
    ta.c = {8'h98, 8'h76, 8'h54};

    bp_tab[0]  = '{full: 1'b0, word: 32'h0000_0000};
    bp_tab[1]  = '{full: 1'b0, word: 32'h3322_1100};
    bp_tab[2]  = '{full: 1'b0, word: 32'h7766_5544};
    bp_tab[3]  = '{full: 1'b1, word: 32'hBBAA_9988};
    bp_tab[4]  = '{full: 1'b1, word: 32'hBBAA_9988};
    bp_tab[5]  = '{full: 1'b1, word: 32'hBBAA_9988};
    bp_tab[6]  = '{full: 1'b0, word: 32'hBBAA_9988};
    bp_tab[7]  = '{full: 1'b0, word: 32'hFFEE_DDCC};
    bp_tab[8]  = '{full: 1'b0, word: 32'h7654_3210};
    bp_tab[9]  = '{full: 1'b0, word: 32'h0000_0098};
    bp_tab[10] = '{full: 1'b0, word: 32'h0000_0001};

    n_rst             = 1'b0;
    texel_valid       = 1'b0;
    ahb_buffer_full   = 1'b0;
    texel_vertices_in = '0;
    texel_color_in    = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", {31'd0, ahb_write_valid}, 32'd0);
    chk("rst_buf", ahb_write_buffer, 32'h0);
    chk("rst_accept_held", {31'd0, texel_accept}, 32'd0);
    n_rst = 1'b1;
    @(negedge clk);
    chk("rst_accept_after", {31'd0, texel_accept}, 32'd1);
    chk("rst_buf_after", ahb_write_buffer, 32'h0);

    // Single texel, 8 consecutive words, then loopback unpack
    capture(ta);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("single_w%0d", k), ahb_write_buffer, frame_word(ta, k));
      chk($sformatf("single_vld%0d", k), {31'd0, ahb_write_valid}, 32'd1);
      chk($sformatf("single_acc%0d", k), {31'd0, texel_accept}, 32'd0);
      w8[k] = ahb_write_buffer;
      @(negedge clk);
    end
    chk("single_idle_accept", {31'd0, texel_accept}, 32'd1);
    chk("single_idle_vld", {31'd0, ahb_write_valid}, 32'd0);
    chk("single_idle_buf", ahb_write_buffer, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      lb.v[2*k-2] = w8[k][15:0];
      lb.v[2*k-1] = w8[k][31:16];
    end
    lb.v[8] = w8[5][15:0];
    lb.c[0] = w8[5][23:16];
    lb.c[1] = w8[5][31:24];
    lb.c[2] = w8[6][7:0];
    chk("loop_start", w8[0], START_W);
    chk("loop_end", w8[7], END_W);
    for (int i = 0; i < 9; i++) chk($sformatf("loop_v%0d", i), {16'd0, lb.v[i]}, {16'd0, ta.v[i]});
    for (int i = 0; i < 3; i++) chk($sformatf("loop_c%0d", i), {24'd0, lb.c[i]}, {24'd0, ta.c[i]});

    // Backpressure at index 3 for three cycles
    capture(ta);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("bp_w%0d", i), ahb_write_buffer, bp_tab[i].word);
      chk($sformatf("bp_vld%0d", i), {31'd0, ahb_write_valid}, 32'd1);
      ahb_buffer_full = bp_tab[i].full;
      @(negedge clk);
    end
    ahb_buffer_full = 1'b0;
    chk("bp_idle_vld", {31'd0, ahb_write_valid}, 32'd0);
    chk("bp_idle_accept", {31'd0, texel_accept}, 32'd1);

    // Inputs change during SEND with texel_valid held high
    tb = rand_tx();
    capture(ta);
    drive_tx(tb);
    texel_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("hold_w%0d", k), ahb_write_buffer, frame_word(ta, k));
      chk($sformatf("hold_acc%0d", k), {31'd0, texel_accept}, 32'd0);
      @(negedge clk);
    end
    chk("hold_accept_after_end", {31'd0, texel_accept}, 32'd1);
    @(negedge clk);
    texel_valid = 1'b0;
    chk("hold_second_start", ahb_write_buffer, START_W);
    chk("hold_second_vld", {31'd0, ahb_write_valid}, 32'd1);
    @(negedge clk);
    chk("hold_second_w1", ahb_write_buffer, frame_word(tb, 1));
    drain();

    // Reset mid-frame at index 4
    capture(ta);
    repeat (4) @(negedge clk);
    chk("mid_w4", ahb_write_buffer, frame_word(ta, 4));
    n_rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_vld", {31'd0, ahb_write_valid}, 32'd0);
    chk("mid_rst_buf", ahb_write_buffer, 32'h0);
    chk("mid_rst_accept", {31'd0, texel_accept}, 32'd0);
    n_rst = 1'b1;
    @(negedge clk);
    chk("mid_rel_accept", {31'd0, texel_accept}, 32'd1);
    chk("mid_rel_vld", {31'd0, ahb_write_valid}, 32'd0);
    capture(tb);
    chk("mid_next_start", ahb_write_buffer, START_W);
    @(negedge clk);
    chk("mid_next_w1", ahb_write_buffer, frame_word(tb, 1));
    drain();

    // Buffer-full while idle does not block capture
    ahb_buffer_full = 1'b1;
    drive_tx(ta);
    texel_valid = 1'b1;
    @(negedge clk);
    texel_valid = 1'b0;
    chk("idlefull_vld", {31'd0, ahb_write_valid}, 32'd1);
    chk("idlefull_start", ahb_write_buffer, START_W);
    @(negedge clk);
    chk("idlefull_held", ahb_write_buffer, START_W);
    ahb_buffer_full = 1'b0;
    @(negedge clk);
    chk("idlefull_w1", ahb_write_buffer, frame_word(ta, 1));
    drain();

    // Randomized traffic against a queue of expected words
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tx_t t;
      chk("rnd_accept", {31'd0, texel_accept}, {31'd0, q.size() == 0});
      chk("rnd_vld", {31'd0, ahb_write_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) chk("rnd_word", ahb_write_buffer, q[0]);
      t = rand_tx();
      drive_tx(t);
      texel_valid     = 1'($urandom_range(0, 1));
      ahb_buffer_full = ($urandom_range(0, 3) == 0);
      if (q.size() != 0) begin
        if (!ahb_buffer_full) void'(q.pop_front());
      end else if (texel_valid) begin
        for (int k = 0; k < 8; k++) q.push_back(frame_word(t, k));
      end
      @(negedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/texel_serializer.md
TEXEL_SERIALIZER -- requirements
Module: texel_serializer

Interface
REQ-001 SHALL have parameter FRAME_START, default 32'd0, frame-start marker word.
REQ-002 SHALL have parameter FRAME_END, default 32'd1, frame-end marker word.
REQ-003 SHALL have port clk  input  1  system clock; the single clock of the block.
REQ-004 SHALL have port n_rst  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port texel_vertices_in  input  Triangle3D  triangle p/q/r, each x/y/z 16 bit.
REQ-006 SHALL have port texel_color_in  input  Color  r/g/b, 8 bit each.
REQ-007 SHALL have port texel_valid  input  1  producer offers a texel.
REQ-008 SHALL have port texel_accept  output  1  block can capture a texel this cycle.
REQ-009 SHALL have port ahb_write_buffer  output  32  current outgoing word.
REQ-010 SHALL have port ahb_write_valid  output  1  ahb_write_buffer holds a valid word.
REQ-011 SHALL have port ahb_buffer_full  input  1  AHB write buffer cannot take a word this cycle.

Function
REQ-012 SHALL implement states IDLE and SEND, with a 3-bit word index (0..7) used in SEND.
REQ-013 In IDLE, texel_accept SHALL be 1; in SEND it SHALL be 0.
REQ-014 On a rising edge with texel_valid=1 and texel_accept=1, the block SHALL latch both inputs into a 168-bit holding register, enter SEND and set index=0.
REQ-015 texel_valid SHALL be ignored while texel_accept=0, and later input changes SHALL NOT affect the latched frame.
REQ-016 In SEND, ahb_write_valid SHALL be 1, and a word SHALL transfer on an edge where ahb_write_valid=1 and ahb_buffer_full=0.
REQ-017 ahb_write_buffer by index SHALL be: 0 = FRAME_START, 1 = {p.y,p.x}, 2 = {q.x,p.z}, 3 = {q.z,q.y}, 4 = {r.y,r.x}, 5 = {color.g,color.r,r.z}, 6 = {24'h0,color.b}, 7 = FRAME_END.
REQ-018 Each transfer SHALL increment the index by exactly 1.
REQ-019 The transfer at index 7 SHALL return the block to IDLE with index 0.
REQ-020 While ahb_buffer_full=1, index, ahb_write_buffer and ahb_write_valid SHALL hold unchanged (no skipped or duplicated words).
REQ-021 In IDLE, ahb_write_valid SHALL be 0 and ahb_write_buffer SHALL be 32'h0.
REQ-022 Minimum latency SHALL be: FRAME_START valid the cycle after capture, FRAME_END valid 7 cycles later, next capture one cycle after FRAME_END transfers (9-cycle texel period without backpressure).
REQ-023 ahb_buffer_full asserted during IDLE SHALL have no effect, and capture SHALL still occur.

Reset
REQ-024 When n_rst=0 at a rising edge, the block SHALL enter IDLE with index=0 and the holding register cleared.
REQ-025 Reset outputs SHALL be: texel_accept=1 after reset deasserts (0 while n_rst=0), ahb_write_valid=0, ahb_write_buffer=32'h0.
REQ-026 Reset mid-frame SHALL abort the frame with no FRAME_END emitted, and the next frame SHALL restart with FRAME_START.

Structure
REQ-027 Triangle3D, Color, FRAME_START/FRAME_END values and the word-index encoding SHALL reside in the shared defines package.
REQ-028 The block SHALL have no sub-modules; the FSM, index counter, holding register and word mux SHALL be in one module.
REQ-029 The word packing SHALL be the exact inverse of texel_assembler, so that serializer output fed to texel_assembler reproduces the input texel.

Verification
REQ-030 Reset: hold n_rst=0 for 2 clocks -> ahb_write_valid=0, ahb_write_buffer=0; after release, texel_accept=1.
REQ-031 Single texel, no backpressure: p={x 1100,y 3322,z 5544}, q={x 7766,y 9988,z BBAA}, r={x DDCC,y FFEE,z 3210}, color={r 54,g 76,b 98} -> words 0, 33221100, 77665544, BBAA9988, FFEEDDCC, 76543210, 00000098, 1 on 8 consecutive cycles, then texel_accept=1.
REQ-032 Backpressure: ahb_buffer_full=1 for 3 cycles while index=3 -> word BBAA9988 held for 4 cycles, then sequence resumes with no loss or repeat.
REQ-033 Input change: alter texel_vertices_in and hold texel_valid=1 during SEND -> emitted frame unchanged, and the second texel captured only after FRAME_END transfers.
REQ-034 Reset mid-frame: n_rst=0 at index=4 -> next edge IDLE and valid=0; the next texel begins with FRAME_START.
REQ-035 Loopback: serializer output connected to texel_assembler -> texel_vertices_out/texel_color_out equal the inputs of REQ-031, and texel_ready=1.
